// File: rtl/voice_scheduler_if.sv
// Engine-side request/response channel of the voice scheduler.
// The master modport is the scheduler and the slave modport is the shared synthesis engine.
interface voice_scheduler_if #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 24
);
  localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                           req_valid;
  logic                           req_ready;
  logic [VW-1:0]                  req_voice;
  logic [6:0]                     req_note;
  logic [6:0]                     req_velocity;
  logic                           resp_valid;
  logic signed [SAMPLE_WIDTH-1:0] resp_sample;

  modport master (
    output req_valid, req_voice, req_note, req_velocity,
    input  req_ready, resp_valid, resp_sample
  );

  modport slave (
    input  req_valid, req_voice, req_note, req_velocity,
    output req_ready, resp_valid, resp_sample
  );
endinterface

// File: rtl/voice_scheduler.sv
// Time-multiplexes one synthesis engine across NUM_VOICES slots and emits one mixed sample per tick.
// Define VOICE_SCHEDULER_SATURATE_EN for a clamped voice sum instead of the default average.
module voice_scheduler #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 24
) (
  input  logic                           clock_50_000_000,
  input  logic                           reset,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0][14:0]    pipeline_notes,
  voice_scheduler_if.master              eng,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           sample_valid,
  output logic                           overrun,
  output logic                           busy
);
  localparam int LOG2 = $clog2(NUM_VOICES);
  localparam int VW   = (LOG2 > 0) ? LOG2 : 1;
  localparam int PW   = LOG2 + 1;
  localparam int AW   = SAMPLE_WIDTH + LOG2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                         state_q, state_d;
  logic [PW-1:0]                  ptr_q, ptr_d;
  logic signed [AW-1:0]           acc_q, acc_d;
  logic [NUM_VOICES-1:0]          snap_active_q, snap_active_d;
  logic [NUM_VOICES-1:0][6:0]     snap_note_q, snap_note_d;
  logic [NUM_VOICES-1:0][6:0]     snap_vel_q, snap_vel_d;
  logic signed [SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
  logic                           sample_valid_q, sample_valid_d;
  logic                           overrun_q, overrun_d;

  logic [VW-1:0]                  slot;
  logic                           last_slot;
  logic signed [AW-1:0]           resp_ext;
  logic signed [SAMPLE_WIDTH-1:0] result;

  assign slot      = ptr_q[VW-1:0];
  assign last_slot = (ptr_q == PW'(NUM_VOICES - 1));
  assign resp_ext  = {{LOG2{eng.resp_sample[SAMPLE_WIDTH-1]}}, eng.resp_sample};

`ifdef VOICE_SCHEDULER_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(LOG2 + 1){1'b0}}, {(SAMPLE_WIDTH - 1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(LOG2 + 1){1'b1}}, {(SAMPLE_WIDTH - 1){1'b0}}};

  always_comb begin
    if (acc_q > SAT_MAX)      result = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (acc_q < SAT_MIN) result = SAT_MIN[SAMPLE_WIDTH-1:0];
    else                      result = acc_q[SAMPLE_WIDTH-1:0];
  end
`else
  // Dropping the low LOG2 bits is the arithmetic shift, so rounding is toward -inf.
  logic unused_acc_lsbs;
  assign result          = acc_q[AW-1:LOG2];
  assign unused_acc_lsbs = ^acc_q[LOG2-1:0];
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    acc_d          = acc_q;
    snap_active_d  = snap_active_q;
    snap_note_d    = snap_note_q;
    snap_vel_d     = snap_vel_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    overrun_d      = sample_tick && (state_q != IDLE);
    eng.req_valid    = 1'b0;
    eng.req_voice    = slot;
    eng.req_note     = snap_note_q[slot];
    eng.req_velocity = snap_vel_q[slot];

    unique case (state_q)
      IDLE: begin
        if (sample_tick) begin
          for (int i = 0; i < NUM_VOICES; i++) begin
            snap_active_d[i] = pipeline_notes[i][14];
            snap_note_d[i]   = pipeline_notes[i][13:7];
            snap_vel_d[i]    = pipeline_notes[i][6:0];
          end
          ptr_d   = '0;
          acc_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Leaving straight to DONE from the last slot keeps the idle frame at NUM_VOICES+2 cycles.
        if (ptr_q == PW'(NUM_VOICES)) begin
          state_d = DONE;
        end else if (!snap_active_q[slot]) begin
          ptr_d   = ptr_q + PW'(1);
          state_d = last_slot ? DONE : ISSUE;
        end else begin
          eng.req_valid = 1'b1;
          if (eng.req_ready) state_d = WAIT;
        end
      end
      WAIT: begin
        if (eng.resp_valid) begin
          acc_d   = acc_q + resp_ext;
          ptr_d   = ptr_q + PW'(1);
          state_d = last_slot ? DONE : ISSUE;
        end
      end
      DONE: begin
        sample_out_d   = result;
        sample_valid_d = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the snapshot table is a handful of flops, so it is reset along with the rest of the state.
  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      acc_q          <= '0;
      snap_active_q  <= '0;
      snap_note_q    <= '0;
      snap_vel_q     <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      acc_q          <= acc_d;
      snap_active_q  <= snap_active_d;
      snap_note_q    <= snap_note_d;
      snap_vel_q     <= snap_vel_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: behavioural engine plus request and sample scoreboards.
// Expected mixes are hand-derived constants for both the averaging and saturating builds.
module tb_voice_scheduler;
  localparam int N  = 4;
  localparam int SW = 24;

  typedef struct packed {
    logic [1:0] voice;
    logic [6:0] note;
    logic [6:0] vel;
  } req_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic [N-1:0][14:0]   notes = '0;
  logic signed [SW-1:0] sample_out;
  logic                 sample_valid, overrun, busy;

  voice_scheduler_if #(.NUM_VOICES(N), .SAMPLE_WIDTH(SW)) eng ();

  voice_scheduler #(.NUM_VOICES(N), .SAMPLE_WIDTH(SW)) dut (
    .clock_50_000_000 (clk),
    .reset            (rst),
    .sample_tick      (tick),
    .pipeline_notes   (notes),
    .eng              (eng.master),
    .sample_out       (sample_out),
    .sample_valid     (sample_valid),
    .overrun          (overrun),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_hs = 0;
  int n_frames = 0;
  int n_overrun = 0;
  int n_valid_cycles = 0;
  int stall_left = 0;
  int resp_delay = 0;

  req_t                 exp_req_q[$];
  logic signed [SW-1:0] exp_smp_q[$];
  logic signed [SW-1:0] resp_tab[N];

  // Behavioural engine: optional stall on the next request, response resp_delay cycles after handshake.
  initial begin : engine
    bit       hs_pend = 0;
    bit       resp_pend = 0;
    int       resp_cnt = 0;
    int       hs_voice = 0;
    req_t     got;
    eng.req_ready   = 1'b0;
    eng.resp_valid  = 1'b0;
    eng.resp_sample = '0;
    forever begin
      @(negedge clk);
      eng.resp_valid = 1'b0;
      eng.req_ready  = 1'b0;
      if (rst) begin
        hs_pend   = 0;
        resp_pend = 0;
      end else begin
        if (hs_pend) begin
          hs_pend   = 0;
          resp_pend = 1;
          resp_cnt  = resp_delay;
        end
        if (resp_pend) begin
          if (resp_cnt == 0) begin
            eng.resp_valid  = 1'b1;
            eng.resp_sample = resp_tab[hs_voice];
            resp_pend = 0;
          end else begin
            resp_cnt--;
          end
        end
        if (eng.req_valid === 1'b1) begin
          n_valid_cycles++;
          got = {eng.req_voice, eng.req_note, eng.req_velocity};
          n_cmp++;
          if (exp_req_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_request got %h required none", got);
          end else begin
            if (got !== exp_req_q[0]) begin
              n_bad++;
              $display("FAIL req_payload got %h required %h", got, exp_req_q[0]);
            end
            if (stall_left > 0) begin
              stall_left--;
            end else begin
              eng.req_ready = 1'b1;
              hs_pend  = 1;
              hs_voice = int'(eng.req_voice);
              void'(exp_req_q.pop_front());
              n_hs++;
            end
          end
        end
      end
    end
  end

  initial begin : sample_monitor
    logic signed [SW-1:0] exp;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sample_valid === 1'b1) begin
          n_frames++;
          n_cmp++;
          if (exp_smp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_sample got %0d required none", sample_out);
          end else begin
            exp = exp_smp_q.pop_front();
            if (sample_out !== exp) begin
              n_bad++;
              $display("FAIL sample_out got %0d required %0d", sample_out, exp);
            end
          end
        end
        if (overrun === 1'b1) n_overrun++;
      end
    end
  end

  function automatic logic [14:0] on_note(input int note, input int vel);
    return {1'b1, 7'(note), 7'(vel)};
  endfunction

  task automatic push_frame(input logic signed [SW-1:0] exp_sample);
    for (int i = 0; i < N; i++) begin
      if (notes[i][14]) exp_req_q.push_back('{voice: 2'(i), note: notes[i][13:7], vel: notes[i][6:0]});
    end
    exp_smp_q.push_back(exp_sample);
  endtask

  task automatic start_frame(input logic signed [SW-1:0] exp_sample);
    @(negedge clk);
    tick = 1'b1;
    push_frame(exp_sample);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic wait_frame(input int target, input string name);
    int c = 0;
    while (n_frames < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_cmp++;
    if (n_frames < target) begin
      n_bad++;
      $display("FAIL %s_timeout got %0d frames required %0d", name, n_frames, target);
    end
  endtask

  task automatic wait_in_wait(input int hs0, input string name);
    int c = 0;
    while (n_hs == hs0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    n_cmp++;
    if (!(busy === 1'b1 && eng.req_valid === 1'b0)) begin
      n_bad++;
      $display("FAIL %s_in_wait got busy=%b req_valid=%b required busy=1 req_valid=0", name, busy, eng.req_valid);
    end
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_req_q.size() != 0 || exp_smp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drained got req=%0d smp=%0d pending required 0/0", name, exp_req_q.size(), exp_smp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({sample_out, sample_valid, overrun, busy, eng.req_valid, eng.req_voice, eng.req_note, eng.req_velocity} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got out=%0d sv=%b ov=%b busy=%b rv=%b voice=%0d note=%0d vel=%0d required all 0",
               sample_out, sample_valid, overrun, busy, eng.req_valid, eng.req_voice, eng.req_note, eng.req_velocity);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_idle();
    notes = '0;
    @(negedge clk);
    tick = 1'b1;
    push_frame('0);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) tick = 1'b0;
      n_cmp++;
      if (busy !== (k <= 5) || sample_valid !== (k == 6) || eng.req_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_timing cycle %0d got busy=%b sv=%b rv=%b required busy=%b sv=%b rv=0",
                 k, busy, sample_valid, eng.req_valid, k <= 5, k == 6);
      end
    end
    check_drained("idle");
  endtask

  task automatic test_single_voice();
    int f0 = n_frames;
    int hs0 = n_hs;
    notes      = '0;
    notes[2]   = on_note(10, 20);
    resp_tab[2] = 24'sd1000;
    resp_delay = 0;
`ifdef VOICE_SCHEDULER_SATURATE_EN
    start_frame(24'sd1000);
`else
    start_frame(24'sd250);
`endif
    wait_frame(f0 + 1, "single");
    n_cmp++;
    if (n_hs - hs0 != 1) begin
      n_bad++;
      $display("FAIL single_req_count got %0d required 1", n_hs - hs0);
    end
    check_drained("single");
  endtask

  task automatic test_extremes();
    int f0 = n_frames;
    notes    = '0;
    notes[0] = on_note(60, 100);
    notes[1] = on_note(64, 90);
    resp_tab[0] = 24'sd8388607;
    resp_tab[1] = 24'sd8388607;
`ifdef VOICE_SCHEDULER_SATURATE_EN
    start_frame(24'sd8388607);
`else
    start_frame(24'sd4194303);
`endif
    wait_frame(f0 + 1, "max");
    resp_tab[0] = -24'sd8388608;
    resp_tab[1] = -24'sd8388608;
`ifdef VOICE_SCHEDULER_SATURATE_EN
    start_frame(-24'sd8388608);
`else
    start_frame(-24'sd4194304);
`endif
    wait_frame(f0 + 2, "min");
    check_drained("extremes");
  endtask

  task automatic test_stall();
    int f0 = n_frames;
    int hs0 = n_hs;
    int v0 = n_valid_cycles;
    notes    = '0;
    notes[0] = on_note(33, 44);
    notes[1] = on_note(55, 66);
    resp_tab[0] = 24'sd100;
    resp_tab[1] = -24'sd300;
    stall_left = 3;
`ifdef VOICE_SCHEDULER_SATURATE_EN
    start_frame(-24'sd200);
`else
    start_frame(-24'sd50);
`endif
    wait_frame(f0 + 1, "stall");
    n_cmp++;
    if (n_hs - hs0 != 2 || n_valid_cycles - v0 != 5) begin
      n_bad++;
      $display("FAIL stall_handshake got hs=%0d valid_cycles=%0d required hs=2 valid_cycles=5",
               n_hs - hs0, n_valid_cycles - v0);
    end
    check_drained("stall");
  endtask

  task automatic test_overrun_snapshot();
    int f0 = n_frames;
    int hs0 = n_hs;
    int o0 = n_overrun;
    notes    = '0;
    notes[0] = on_note(1, 2);
    notes[3] = on_note(3, 4);
    resp_tab[0] = 24'sd4000;
    resp_tab[3] = -24'sd1000;
    resp_delay = 4;
`ifdef VOICE_SCHEDULER_SATURATE_EN
    start_frame(24'sd3000);
`else
    start_frame(24'sd750);
`endif
    wait_in_wait(hs0, "overrun");
    tick = 1'b1;
    notes[3][14] = 1'b0;
    @(negedge clk);
    tick = 1'b0;
    wait_frame(f0 + 1, "overrun");
    repeat (12) @(negedge clk);
    n_cmp++;
    if (n_overrun - o0 != 1 || n_hs - hs0 != 2 || busy !== 1'b0 || n_frames != f0 + 1) begin
      n_bad++;
      $display("FAIL overrun_frame got ov=%0d hs=%0d busy=%b frames=%0d required ov=1 hs=2 busy=0 frames=%0d",
               n_overrun - o0, n_hs - hs0, busy, n_frames, f0 + 1);
    end
    resp_delay = 0;
    check_drained("overrun");
  endtask

  task automatic test_reset_midframe();
    int f0;
    int hs0 = n_hs;
    notes    = '0;
    notes[1] = on_note(70, 80);
    resp_tab[1] = 24'sd500;
    resp_delay = 20;
    start_frame(24'sd0);
    wait_in_wait(hs0, "midreset");
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (eng.req_valid !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got rv=%b busy=%b sv=%b required 0/0/0", eng.req_valid, busy, sample_valid);
    end
    exp_req_q.delete();
    exp_smp_q.delete();
    resp_delay = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    f0 = n_frames;
`ifdef VOICE_SCHEDULER_SATURATE_EN
    start_frame(24'sd500);
`else
    start_frame(24'sd125);
`endif
    wait_frame(f0 + 1, "after_reset");
    check_drained("after_reset");
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) resp_tab[i] = '0;
    test_reset();
    test_all_idle();
    test_single_voice();
    test_extremes();
    test_stall();
    test_overrun_snapshot();
    test_reset_midframe();
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
